// File: rtl/seq_sub_16b_if.sv
// ---------------------------------------------------------------------------
// seq_sub_16b_if
// Request/result bundle for the sequential 16-bit subtractor.
//   start  : request, sampled on the rising clock edge
//   a, b   : minuend / subtrahend, only meaningful on the accepting edge
//   busy   : subtraction in progress
//   done   : one-cycle pulse, result fields valid
//   diff   : a - b modulo 2^16
//   b_out  : unsigned borrow (a < b)
//   ovf    : signed two's-complement overflow
// master drives the request side; slave is the subtractor.
// ---------------------------------------------------------------------------
interface seq_sub_16b_if;
    localparam int unsigned DW = 16;

    logic          start;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] diff;
    logic          b_out;
    logic          ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, b_out, ovf
    );
endinterface

// File: rtl/seq_sub_16b.sv
// ---------------------------------------------------------------------------
// seq_sub_16b
// Nibble-serial 16-bit subtractor: a - b computed as a + ~b + 1, one 4-bit
// slice per clock, four clocks per operation, fixed latency.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_sub_16b_if.slave (start/a/b in; busy/done/diff/b_out/ovf out)
// All outputs are registered; results only update on the completion edge.
// ---------------------------------------------------------------------------
module seq_sub_16b (
    input  logic          clock,
    input  logic          reset_n,
    seq_sub_16b_if.slave  bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_part;
    logic            r_busy;
    logic            r_done;
    logic [DW-1:0]   r_diff;
    logic            r_b_out;
    logic            r_ovf;

    logic [SW-1:0]   w_a_sl;
    logic [SW-1:0]   w_nb_sl;
    logic [SW:0]     w_sum;
    logic            w_c_msb;
    logic [3:0]      w_base;

    // Bit offset of the slice selected by the counter.
    assign w_base  = {r_cnt, 2'b00};
    assign w_a_sl  = r_a[w_base +: SW];
    assign w_nb_sl = ~r_b[w_base +: SW];

    // One slice of a + ~b + carry; bit SW is the slice carry out.
    assign w_sum = (SW+1)'({1'b0, w_a_sl}) + (SW+1)'({1'b0, w_nb_sl}) + (SW+1)'(r_carry);

    // Carry into the slice MSB recovered from its sum bit (s = a ^ b ^ cin).
    assign w_c_msb = w_a_sl[SW-1] ^ w_nb_sl[SW-1] ^ w_sum[SW-1];

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_b_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // start is ignored here; operands stay latched.
                    r_part[w_base +: SW] <= w_sum[SW-1:0];
                    r_carry              <= w_sum[SW];
                    r_cnt                <= CW'(r_cnt + CW'(1));
                    if (r_cnt == CW'(3)) begin
                        r_diff  <= {w_sum[SW-1:0], r_part[DW-SW-1:0]};
                        r_b_out <= ~w_sum[SW];
                        r_ovf   <= w_c_msb ^ w_sum[SW];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.diff  = r_diff;
    assign bus.b_out = r_b_out;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_seq_sub_16b.sv
// ---------------------------------------------------------------------------
// tb_seq_sub_16b
// Directed and random subtraction checks with a result scoreboard: expected
// results are queued when a request is driven and compared on each done.
// ---------------------------------------------------------------------------
module tb_seq_sub_16b;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_sub_16b_if bus ();

    seq_sub_16b dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_done  = 0;
    logic [15:0] prev_diff = 16'h0000;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.d  = a - b;
        e.bo = (a < b);
        e.ov = (a[15] != b[15]) && (e.d[15] != a[15]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b);
        bus.start = s;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare every done pulse against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_diff", 32'(bus.diff), 32'(mon_e.d));
                chk("sb_bout", 32'(bus.b_out), 32'(mon_e.bo));
                chk("sb_ovf",  32'(bus.ovf), 32'(mon_e.ov));
            end
        end
    end

    // One complete operation with cycle-exact busy/done/hold checks.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ebo, input logic eov);
        drive(1'b1, a, b);
        sb_q.push_back(model(a, b));
        tick;                                   // t0: accepted
        drive(1'b0, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_done", 32'(bus.done), 32'd0);
            chk("run_hold", 32'(bus.diff), 32'(prev_diff));
            tick;                               // t1..t4
        end
        chk("fin_busy", 32'(bus.busy), 32'd0);
        chk("fin_done", 32'(bus.done), 32'd1);
        chk("fin_diff", 32'(bus.diff), 32'(ed));
        chk("fin_bout", 32'(bus.b_out), 32'(ebo));
        chk("fin_ovf",  32'(bus.ovf), 32'(eov));
        prev_diff = ed;
        tick;
        chk("post_done", 32'(bus.done), 32'd0);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_hold", 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        exp_t e;
        logic [15:0] ra, rb;

        drive(1'b0, 16'h0, 16'h0);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.b_out), 32'd0);
        chk("rst_ovf",  32'(bus.ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First start goes in on the first rising edge out of reset.
        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

        // start during RUN ignored; back-to-back start in the DONE cycle.
        drive(1'b1, 16'h1234, 16'h1234);
        sb_q.push_back(model(16'h1234, 16'h1234));
        tick;                                   // t0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hFFFF, 16'h0000);
            chk("ign_busy", 32'(bus.busy), 32'd1);
            tick;                               // t1..t4
        end
        chk("eq_done", 32'(bus.done), 32'd1);
        chk("eq_diff", 32'(bus.diff), 32'h0000);
        chk("eq_bout", 32'(bus.b_out), 32'd0);
        chk("eq_ovf",  32'(bus.ovf), 32'd0);
        drive(1'b1, 16'h0010, 16'h0001);
        sb_q.push_back(model(16'h0010, 16'h0001));
        tick;                                   // t5: accepted from DONE
        drive(1'b0, 16'hAAAA, 16'h5555);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done", 32'(bus.done), 32'd0);
        chk("b2b_hold", 32'(bus.diff), 32'h0000);
        repeat (3) tick;
        chk("b2b_run",  32'(bus.busy), 32'd1);
        tick;                                   // t9
        chk("b2b_fin",  32'(bus.done), 32'd1);
        chk("b2b_diff", 32'(bus.diff), 32'h000F);
        tick;
        chk("b2b_idle", 32'(bus.done), 32'd0);
        prev_diff = 16'h000F;

        // Reset mid-operation after slice 1.
        drive(1'b1, 16'h00FF, 16'h0001);
        sb_q.push_back(model(16'h00FF, 16'h0001));
        tick;                                   // t0
        drive(1'b0, 16'h0, 16'h0);
        tick;                                   // t1
        tick;                                   // t2
        chk("ab_busy", 32'(bus.busy), 32'd1);
        chk("ab_hold", 32'(bus.diff), 32'h000F);
        rst_n = 1'b0;
        e = sb_q.pop_back();
        #1;
        chk("ab_rbusy", 32'(bus.busy), 32'd0);
        chk("ab_rdone", 32'(bus.done), 32'd0);
        chk("ab_rdiff", 32'(bus.diff), 32'd0);
        chk("ab_rbout", 32'(bus.b_out), 32'd0);
        chk("ab_rovf",  32'(bus.ovf), 32'd0);
        d0 = n_done;
        repeat (3) tick;
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = 16'h0000;
        repeat (5) tick;
        chk("ab_nodone", 32'(n_done), 32'(d0));
        chk("ab_idle",   32'(bus.busy), 32'd0);
        run_op(16'h00FF, 16'h0001, 16'h00FE, 1'b0, 1'b0);

        // Random operands, expectations from the model.
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = (i == 3) ? ra : 16'($urandom);
            e  = model(ra, rb);
            run_op(ra, rb, e.d, e.bo, e.ov);
        end

        repeat (2) tick;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("done_cnt", 32'(n_done), 32'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
